// File: rtl/mc_controller.sv
// mc_controller -- multicycle control unit for the 32-bit, 16-register datapath.
//
// Sequences FETCH/DECODE/EXEC/MEM/WB over 2-5 cycles per instruction and holds
// the N/Z/V condition flags used by BEQ/BLT.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   opcode[3:0]              IR[31:28], stable from DECODE on
//   zero/negative/overflow   live ALU flags of the current cycle
//   pc_write, ir_write, reg_write, mem_read, mem_write   strobes
//   iord, alu_src_a, alu_src_b[1:0], alu_control[2:0],
//   mem_to_reg, pc_src, read2_sel                         datapath selects
//   halted                   high in HALT
//   instr_count, cycle_count performance counters
//
// Build option: define CTRL_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module mc_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_control,
    output logic        mem_to_reg,
    output logic        pc_src,
    output logic        read2_sel,
    output logic        halted,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t state_q, state_d;
    logic   n_q, z_q, v_q;
    logic   flag_load;
    logic   taken;

    // MOV/MOVI pass B through the ALU and must not disturb the flags.
    assign flag_load = ((state_q == S_EXEC_R) || (state_q == S_EXEC_I)) &&
                       (opcode inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hD});

    always_comb begin
        taken = 1'b0;
        case (opcode)
            4'hA:    taken = 1'b1;
            4'hB:    taken = z_q;
            4'hC:    taken = n_q ^ v_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD: state_d = S_EXEC_R;
                    4'h5, 4'h6, 4'h7:                   state_d = S_EXEC_I;
                    4'h8, 4'h9:                         state_d = S_MEM_ADDR;
                    4'hA, 4'hB, 4'hC:                   state_d = S_BRANCH;
                    4'hF:                               state_d = S_HALT;
                    default:                            state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = (opcode == 4'hD) ? S_FETCH : S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (opcode == 4'h8) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flag_load) begin
                n_q <= negative;
                z_q <= zero;
                v_q <= overflow;
            end
        end
    end

    // Decoded from the state register; rst gates everything so the strobes
    // drop the moment reset is asserted, not at the next edge.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'd0;
        mem_to_reg  = 1'b0;
        pc_src      = 1'b0;
        read2_sel   = 1'b0;
        halted      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    read2_sel = (opcode == 4'h9);
                end
                S_EXEC_R: begin
                    alu_src_a   = 1'b1;
                    alu_control = (opcode == 4'hD) ? 3'd1 : opcode[2:0];
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        4'h6:    alu_control = 3'd1;
                        4'h7:    alu_control = 3'd4;
                        default: alu_control = 3'd0;
                    endcase
                end
                S_ALU_WB: reg_write = 1'b1;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    read2_sel = 1'b1;
                end
                S_BRANCH: begin
                    pc_write = taken;
                    pc_src   = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_EN
    logic [31:0] instr_q, cycle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            if (state_q != S_HALT)   cycle_q <= cycle_q + 32'd1;
            if (state_q == S_DECODE) instr_q <= instr_q + 32'd1;
        end
    end

    assign instr_count = instr_q;
    assign cycle_count = cycle_q;
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed and random instruction streams checked
// cycle by cycle against a per-instruction reference of expected control words.
module tb_mc_controller;

`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  opcode = 4'hE;
    logic        zero = 1'b0, negative = 1'b0, overflow = 1'b0;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write, iord;
    logic        alu_src_a, mem_to_reg, pc_src, read2_sel, halted;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [31:0] instr_count, cycle_count;

    mc_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .zero(zero), .negative(negative), .overflow(overflow),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .mem_to_reg(mem_to_reg), .pc_src(pc_src), .read2_sel(read2_sel),
        .halted(halted), .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference state: architectural flags and performance counts.
    bit          mz, mn, mv;
    logic [31:0] m_cyc, m_ins;
    bit          force_fl = 1'b0;
    logic [2:0]  ffl = 3'b000;   // {zero, negative, overflow}

    function automatic logic [15:0] outs();
        return {pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_src_a,
                alu_src_b, alu_control, mem_to_reg, pc_src, read2_sel, halted};
    endfunction

    function automatic logic [15:0] mk(input bit pcw, irw, rw, mr, mw, io, asa,
                                       input bit [1:0] asb, input bit [2:0] alu,
                                       input bit m2r, pcs, r2s, h);
        return {pcw, irw, rw, mr, mw, io, asa, asb, alu, m2r, pcs, r2s, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_icnt"}, instr_count, PERF ? m_ins : 32'd0);
        chk({tag, "_ccnt"}, cycle_count, PERF ? m_cyc : 32'd0);
    endtask

    // Runs one instruction; stops before cycle index 'abort_at' if it is reached.
    task automatic run_instr(input logic [3:0] op, input int abort_at = -1);
        logic [15:0] exp_q[$];
        logic [2:0]  alu;
        bit          tk;
        exp_q.push_back(mk(1,1,0,1,0,0,0,2'b01,3'd0,0,0,0,0));
        exp_q.push_back(mk(0,0,0,0,0,0,0,2'b11,3'd0,0,0,(op == 4'h9),0));
        if (op <= 4'h4 || op == 4'hD) begin
            alu = (op == 4'hD) ? 3'd1 : op[2:0];
            exp_q.push_back(mk(0,0,0,0,0,0,1,2'b00,alu,0,0,0,0));
            if (op != 4'hD) exp_q.push_back(mk(0,0,1,0,0,0,0,2'b00,3'd0,0,0,0,0));
        end else if (op <= 4'h7) begin
            alu = (op == 4'h5) ? 3'd0 : (op == 4'h6) ? 3'd1 : 3'd4;
            exp_q.push_back(mk(0,0,0,0,0,0,1,2'b10,alu,0,0,0,0));
            exp_q.push_back(mk(0,0,1,0,0,0,0,2'b00,3'd0,0,0,0,0));
        end else if (op <= 4'h9) begin
            exp_q.push_back(mk(0,0,0,0,0,0,1,2'b10,3'd0,0,0,0,0));
            if (op == 4'h8) begin
                exp_q.push_back(mk(0,0,0,1,0,1,0,2'b00,3'd0,0,0,0,0));
                exp_q.push_back(mk(0,0,1,0,0,0,0,2'b00,3'd0,1,0,0,0));
            end else begin
                exp_q.push_back(mk(0,0,0,0,1,1,0,2'b00,3'd0,0,0,1,0));
            end
        end else if (op <= 4'hC) begin
            tk = (op == 4'hA) ? 1'b1 : (op == 4'hB) ? mz : (mn ^ mv);
            exp_q.push_back(mk(tk,0,0,0,0,0,0,2'b00,3'd0,0,1,0,0));
        end else if (op == 4'hF) begin
            for (int k = 0; k < 100; k++)
                exp_q.push_back(mk(0,0,0,0,0,0,0,2'b00,3'd0,0,0,0,1));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) return;
            @(negedge clk);
            opcode = op;
            if (force_fl) {zero, negative, overflow} = ffl;
            else {zero, negative, overflow} = 3'($urandom_range(0, 7));
            #1;
            chk($sformatf("op%h_c%0d_ctl", op, i), 32'(outs()), 32'(exp_q[i]));
            chk_counters($sformatf("op%h_c%0d", op, i));
            if (i == 2 && (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'hD})) begin
                mz = zero; mn = negative; mv = overflow;
            end
            if (!exp_q[i][0]) m_cyc = m_cyc + 32'd1;
            if (i == 1)       m_ins = m_ins + 32'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ctl", 32'(outs()), 32'd0);
        chk("rst_icnt", instr_count, 32'd0);
        chk("rst_ccnt", cycle_count, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_ctl", 32'(outs()), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mz = 0; mn = 0; mv = 0;
        m_cyc = '0; m_ins = '0;
    endtask

    task automatic flags_then(input logic [3:0] op, input logic [2:0] f);
        force_fl = 1'b1;
        ffl = f;
        run_instr(op);
        force_fl = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        do_reset();

        // Directed instruction shapes.
        run_instr(4'h0);
        run_instr(4'h8);
        run_instr(4'h9);

        // CMP with Z=1 then BEQ taken; Z=0 then not taken.
        flags_then(4'hD, 3'b100);
        flags_then(4'hB, 3'b000);
        chk("beq_after_cmp_z1", {31'd0, mz}, 32'd1);
        flags_then(4'hD, 3'b000);
        flags_then(4'hB, 3'b111);
        // MOVI between CMP and BEQ keeps Z.
        flags_then(4'hD, 3'b100);
        flags_then(4'h7, 3'b000);
        flags_then(4'hB, 3'b000);
        // BLT: N=1,V=0 taken; N=1,V=1 not taken.
        flags_then(4'hD, 3'b010);
        flags_then(4'hC, 3'b000);
        flags_then(4'hD, 3'b011);
        flags_then(4'hC, 3'b000);

        // Random stream (no HALT).
        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom_range(0, 14)));

        // Reset during EXEC_R of ADD.
        run_instr(4'h0, 2);
        do_reset();

        // ADD, NOP, HALT program; HALT holds for 100 checked cycles.
        run_instr(4'h0);
        run_instr(4'hE);
        run_instr(4'hF);
        chk("perf_instr", instr_count, PERF ? 32'd3 : 32'd0);
        chk("perf_cycle", cycle_count, PERF ? 32'd8 : 32'd0);
        chk("halted_end", {31'd0, halted}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
